// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl: serial memory transfer sequencer.
// A command is sent as an opcode slot, three address slots (MSB first), then
// one 8-cycle byte slot per data byte. Writes are paced by a wr_valid/wr_ready
// handshake. Reads pulse the deserializer and return one byte per slot.
module mem_xfer_ctrl #(
  parameter logic [7:0] OP_READ  = 8'h03,
  parameter logic [7:0] OP_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  ser_data,
  output logic        ser_start,
  output logic        des_start,
  input  logic [7:0]  des_data,
  output logic        cs_n,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  slot_q;
  logic [1:0]  addr_idx_q;
  logic        is_write_q;
  logic [23:0] addr_q;
  logic [8:0]  remain_q;
  logic [7:0]  wbyte_q;
  logic [7:0]  rd_data_q;
  logic        rd_valid_q;

  logic slot_start, slot_end, accept, wr_xfer, slot_hold;

  assign slot_start = (slot_q == 3'd0);
  assign slot_end   = (slot_q == 3'd7);
  assign accept     = cmd_valid && (state_q == IDLE);
  assign wr_xfer    = (state_q == WDATA) && slot_start && wr_valid;
  assign slot_hold  = (state_q == WDATA) && slot_start && !wr_valid;

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // State register; reset drops any transaction in flight straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state outputs; the serial byte is decoded from state so it stays stable for a whole slot.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    ser_start = 1'b0;
    des_start = 1'b0;
    ser_data  = 8'h00;
    cs_n      = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = CMD;
      end
      CMD: begin
        cs_n      = 1'b0;
        ser_start = slot_start;
        ser_data  = is_write_q ? OP_WRITE : OP_READ;
        if (slot_end) state_d = ADDR;
      end
      ADDR: begin
        cs_n      = 1'b0;
        ser_start = slot_start;
        case (addr_idx_q)
          2'd0:    ser_data = addr_q[23:16];
          2'd1:    ser_data = addr_q[15:8];
          default: ser_data = addr_q[7:0];
        endcase
        if (slot_end && addr_idx_q == 2'd2) state_d = is_write_q ? WDATA : RDATA;
      end
      WDATA: begin
        cs_n = 1'b0;
        if (slot_start) begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            ser_start = 1'b1;
            ser_data  = wr_data;
          end
        end else begin
          ser_data = wbyte_q;
        end
        if (slot_end && remain_q == 9'd0) state_d = DONE;
      end
      RDATA: begin
        cs_n      = 1'b0;
        des_start = slot_start;
        if (slot_end && remain_q == 9'd0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot timing, latched command fields, byte countdown and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= 3'd0;
      addr_idx_q <= 2'd0;
      is_write_q <= 1'b0;
      addr_q     <= 24'd0;
      remain_q   <= 9'd0;
      wbyte_q    <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          slot_q     <= 3'd0;
          addr_idx_q <= 2'd0;
          if (accept) begin
            is_write_q <= cmd_write;
            addr_q     <= cmd_addr;
            remain_q   <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
          end
        end
        CMD: slot_q <= slot_q + 3'd1;
        ADDR: begin
          slot_q <= slot_q + 3'd1;
          if (slot_end) addr_idx_q <= addr_idx_q + 2'd1;
        end
        WDATA: begin
          if (!slot_hold) slot_q <= slot_q + 3'd1;
          if (wr_xfer) begin
            wbyte_q  <= wr_data;
            remain_q <= remain_q - 9'd1;
          end
        end
        RDATA: begin
          slot_q <= slot_q + 3'd1;
          if (slot_start) remain_q <= remain_q - 9'd1;
          if (slot_end) begin
            rd_data_q  <= des_data;
            rd_valid_q <= 1'b1;
          end
        end
        DONE: slot_q <= 3'd0;
        default: slot_q <= 3'd0;
      endcase
    end
  end

endmodule
